// File: rtl/lsu_bus_bridge.sv
// RV32I load/store unit bridging the core data port to a handshaked bus.
// Word-aligned bus transactions with byte strobes, load extension, timeout.
module lsu_bus_bridge #(
    parameter int TIMEOUT = 255,
    parameter int CNT_W   = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    input  logic        req_we,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        stall,
    output logic        rsp_done,
    output logic [31:0] rdata,
    output logic        err_misalign,
    output logic        err_timeout,
    output logic        bus_valid,
    input  logic        bus_ready,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_wdata,
    output logic [3:0]  bus_wstrb,
    input  logic        bus_rvalid,
    input  logic [31:0] bus_rdata
);

    typedef enum logic [1:0] {IDLE, ADDR, RESP, DONE} state_t;

    localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT - 1);

    state_t           state, state_n;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic             take, fault, complete, expire, hit;
    logic             legal;
    logic [3:0]       strb;
    logic [31:0]      wdat;
    logic [1:0]       off_q;
    logic [2:0]       f3_q;
    logic [31:0]      shifted, ext;

    always_comb begin
        legal = 1'b0;
        strb  = 4'b0000;
        wdat  = req_wdata;
        unique case (req_funct3)
            3'd0: begin
                legal = 1'b1;
                strb  = 4'b0001 << req_addr[1:0];
                wdat  = {4{req_wdata[7:0]}};
            end
            3'd1: begin
                legal = !req_addr[0];
                strb  = 4'b0011 << req_addr[1:0];
                wdat  = {2{req_wdata[15:0]}};
            end
            3'd2: begin
                legal = (req_addr[1:0] == 2'b00);
                strb  = 4'b1111;
            end
            3'd4: legal = !req_we;
            3'd5: legal = !req_we && !req_addr[0];
            default: legal = 1'b0;
        endcase
        if (!req_we) strb = 4'b0000;
    end

    // Half offsets are always 0 or 2 here, so a byte-granular shift serves both sizes.
    always_comb begin
        shifted = bus_rdata >> {off_q, 3'b000};
        ext     = bus_rdata;
        unique case (f3_q)
            3'd0: ext = {{24{shifted[7]}}, shifted[7:0]};
            3'd4: ext = {24'd0, shifted[7:0]};
            3'd1: ext = {{16{shifted[15]}}, shifted[15:0]};
            3'd5: ext = {16'd0, shifted[15:0]};
            default: ext = bus_rdata;
        endcase
    end

    always_comb begin
        state_n  = state;
        cnt_n    = cnt;
        take     = 1'b0;
        fault    = 1'b0;
        complete = 1'b0;
        expire   = 1'b0;
        hit      = 1'b0;
        unique case (state)
            IDLE: begin
                if (req_valid) begin
                    if (legal) begin
                        take    = 1'b1;
                        cnt_n   = '0;
                        state_n = ADDR;
                    end else begin
                        fault   = 1'b1;
                        state_n = DONE;
                    end
                end
            end
            ADDR, RESP: begin
                hit = (state == ADDR) ? (bus_ready && bus_rvalid)
                                      : bus_rvalid;
                if (hit) begin
                    complete = 1'b1;
                    state_n  = DONE;
                end else if (cnt == LAST) begin
                    expire  = 1'b1;
                    state_n = DONE;
                end else begin
                    cnt_n = cnt + CNT_W'(1);
                    if (state == ADDR && bus_ready) state_n = RESP;
                end
            end
            DONE: state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bus_we       <= 1'b0;
            bus_addr     <= '0;
            bus_wdata    <= '0;
            bus_wstrb    <= '0;
            off_q        <= '0;
            f3_q         <= '0;
            rdata        <= '0;
            err_misalign <= 1'b0;
            err_timeout  <= 1'b0;
        end else begin
            if (take) begin
                bus_we    <= req_we;
                bus_addr  <= {req_addr[31:2], 2'b00};
                bus_wdata <= wdat;
                bus_wstrb <= strb;
                off_q     <= req_addr[1:0];
                f3_q      <= req_funct3;
            end
            err_misalign <= fault;
            err_timeout  <= expire;
            if (fault || expire) begin
                rdata <= '0;
            end else if (complete) begin
                rdata <= bus_we ? 32'd0 : ext;
            end
        end
    end

    assign bus_valid = (state == ADDR);
    assign rsp_done  = (state == DONE);
    assign stall     = req_valid && (state != DONE);

endmodule

// File: tb/tb_lsu_bus_bridge.sv
// Testbench for lsu_bus_bridge: vector table, hand sequences
// and randomized accesses checked against a behavioural model.
module tb_lsu_bus_bridge;

    localparam int TO = 8;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid, req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr, req_wdata;
    logic        stall, rsp_done;
    logic [31:0] rdata;
    logic        err_misalign, err_timeout;
    logic        bus_valid, bus_ready, bus_we;
    logic [31:0] bus_addr, bus_wdata;
    logic [3:0]  bus_wstrb;
    logic        bus_rvalid;
    logic [31:0] bus_rdata;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic        we;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] wdata;
        int          rd;
        int          rv;
        logic [31:0] rword;
        logic        mis;
        logic [3:0]  strb;
        logic [31:0] wd;
        logic [31:0] rdat;
    } vec_t;

    vec_t tbl[$];

    lsu_bus_bridge #(.TIMEOUT(TO), .CNT_W(16)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_we(req_we),
        .req_funct3(req_funct3), .req_addr(req_addr),
        .req_wdata(req_wdata), .stall(stall),
        .rsp_done(rsp_done), .rdata(rdata),
        .err_misalign(err_misalign), .err_timeout(err_timeout),
        .bus_valid(bus_valid), .bus_ready(bus_ready),
        .bus_we(bus_we), .bus_addr(bus_addr),
        .bus_wdata(bus_wdata), .bus_wstrb(bus_wstrb),
        .bus_rvalid(bus_rvalid), .bus_rdata(bus_rdata)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Behavioural reference: access rules expressed as sizes and arithmetic.
    function automatic vec_t model(input vec_t v);
        int size, off;
        logic ok;
        logic [31:0] mask, val;
        size = (v.f3[1:0] == 2'd0) ? 1 : (v.f3[1:0] == 2'd1) ? 2 : 4;
        off  = int'(v.addr[1:0]);
        ok   = (v.f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5})
               && !(v.we && v.f3[2]) && (off % size == 0);
        v.mis  = !ok;
        v.strb = v.we ? 4'(((1 << size) - 1) << off) : 4'd0;
        mask   = (size == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * size)) - 1);
        if (size == 1) v.wd = {24'd0, v.wdata[7:0]} * 32'h0101_0101;
        else if (size == 2) v.wd = {16'd0, v.wdata[15:0]} * 32'h0001_0001;
        else v.wd = v.wdata;
        val = (v.rword >> (8 * off)) & mask;
        if (!v.f3[2] && size < 4 && val[8 * size - 1]) val = val | ~mask;
        v.rdat = (ok && !v.we) ? val : 32'd0;
        return v;
    endfunction

    // Entered and left at posedge+1; bus cycle k is t-1 from the request cycle.
    task automatic run_access(input vec_t v, input string nm);
        int exp_t, exp_valid, done_t, vcnt, t, k;
        bit timed, fin, stall_bad, moved;
        logic [31:0] exp_rd, got_rd, a0, w0;
        logic [3:0] s0;
        logic we0, got_mis, got_to;
        timed = !v.mis && (v.rv > TO - 1);
        if (v.mis) begin
            exp_t = 1;
            exp_valid = 0;
        end else begin
            exp_t = timed ? TO + 1 : v.rv + 2;
            exp_valid = ((v.rd < TO - 1) ? v.rd : TO - 1) + 1;
        end
        exp_rd = timed ? 32'd0 : v.rdat;
        req_valid = 1'b1;
        req_we = v.we;
        req_funct3 = v.f3;
        req_addr = v.addr;
        req_wdata = v.wdata;
        done_t = -1; vcnt = 0; t = 0;
        fin = 0; stall_bad = 0; moved = 0;
        got_rd = '0; got_mis = 0; got_to = 0;
        a0 = '0; w0 = '0; s0 = '0; we0 = 0;
        while (!fin && t < TO + 30) begin
            k = t - 1;
            bus_ready = (k >= v.rd);
            bus_rvalid = (k == v.rv);
            bus_rdata = (k == v.rv) ? v.rword : $urandom;
            @(negedge clk);
            if (bus_valid) begin
                if (vcnt == 0) begin
                    a0 = bus_addr; s0 = bus_wstrb;
                    w0 = bus_wdata; we0 = bus_we;
                end else if (bus_addr !== a0 || bus_wstrb !== s0 ||
                             bus_wdata !== w0 || bus_we !== we0) begin
                    moved = 1;
                end
                vcnt++;
            end
            if (rsp_done) begin
                done_t = t;
                got_rd = rdata;
                got_mis = err_misalign;
                got_to = err_timeout;
                if (stall !== 1'b0) stall_bad = 1;
                fin = 1;
            end else if (stall !== 1'b1) begin
                stall_bad = 1;
            end
            @(posedge clk); #1;
            t++;
        end
        req_valid = 1'b0;
        bus_ready = 1'b0;
        bus_rvalid = 1'b0;
        chk({nm, "/latency"}, 32'(done_t), 32'(exp_t));
        chk({nm, "/valid_cycles"}, 32'(vcnt), 32'(exp_valid));
        chk({nm, "/stall"}, 32'(stall_bad), 32'd0);
        chk({nm, "/rdata"}, got_rd, exp_rd);
        chk({nm, "/err_misalign"}, 32'(got_mis), 32'(v.mis));
        chk({nm, "/err_timeout"}, 32'(got_to), 32'(timed));
        if (exp_valid > 0) begin
            chk({nm, "/bus_addr"}, a0, {v.addr[31:2], 2'b00});
            chk({nm, "/bus_wstrb"}, 32'(s0), 32'(v.strb));
            chk({nm, "/bus_we"}, 32'(we0), 32'(v.we));
            chk({nm, "/stable"}, 32'(moved), 32'd0);
            if (v.we) chk({nm, "/bus_wdata"}, w0, v.wd);
        end
        @(negedge clk);
        chk({nm, "/single_pulse"}, 32'(rsp_done), 32'd0);
        chk({nm, "/idle_after"}, 32'(bus_valid), 32'd0);
        chk({nm, "/rdata_hold"}, rdata, exp_rd);
        @(posedge clk); #1;
    endtask

    initial begin
        vec_t v;
        reset = 1'b1;
        req_valid = 0; req_we = 0; req_funct3 = 0;
        req_addr = 0; req_wdata = 0;
        bus_ready = 0; bus_rvalid = 0; bus_rdata = 0;

        // we f3 addr wdata rd rv rword | mis strb wd rdat
        tbl.push_back('{0, 2, 32'h100, 0, 0, 2, 32'hDEADBEEF,
                        0, 0, 0, 32'hDEADBEEF});
        tbl.push_back('{0, 0, 32'h103, 0, 0, 0, 32'h80112233,
                        0, 0, 0, 32'hFFFFFF80});
        tbl.push_back('{0, 4, 32'h103, 0, 1, 2, 32'h80112233,
                        0, 0, 0, 32'h00000080});
        tbl.push_back('{1, 1, 32'h0A2, 32'h1234ABCD, 3, 3, 0,
                        0, 4'hC, 32'hABCDABCD, 0});
        tbl.push_back('{0, 2, 32'h101, 0, 0, 0, 0, 1, 0, 0, 0});
        tbl.push_back('{1, 1, 32'h003, 0, 0, 0, 0, 1, 0, 0, 0});
        tbl.push_back('{0, 3, 32'h040, 0, 0, 0, 0, 1, 0, 0, 0});
        tbl.push_back('{1, 5, 32'h044, 0, 0, 0, 0, 1, 0, 0, 0});
        tbl.push_back('{0, 2, 32'h200, 0, 0, 8, 32'h11111111,
                        0, 0, 0, 0});
        tbl.push_back('{0, 2, 32'h204, 0, 1, 1, 32'h13579BDF,
                        0, 0, 0, 32'h13579BDF});
        tbl.push_back('{0, 1, 32'h102, 0, 0, 1, 32'h80017FFF,
                        0, 0, 0, 32'hFFFF8001});
        tbl.push_back('{0, 5, 32'h102, 0, 0, 1, 32'h80017FFF,
                        0, 0, 0, 32'h00008001});
        tbl.push_back('{0, 1, 32'h100, 0, 0, 1, 32'h80017FFF,
                        0, 0, 0, 32'h00007FFF});
        tbl.push_back('{1, 0, 32'h007, 32'h000000A5, 0, 0, 0,
                        0, 4'h8, 32'hA5A5A5A5, 0});
        tbl.push_back('{1, 2, 32'h010, 32'hCAFEF00D, 2, 2, 0,
                        0, 4'hF, 32'hCAFEF00D, 0});
        tbl.push_back('{0, 2, 32'h300, 0, 20, 20, 0, 0, 0, 0, 0});
        tbl.push_back('{0, 4, 32'h101, 0, 2, 4, 32'h0000FE00,
                        0, 0, 0, 32'h000000FE});

        repeat (2) @(posedge clk);
        #1;
        chk("reset/bus_valid", 32'(bus_valid), 0);
        chk("reset/rsp_done", 32'(rsp_done), 0);
        chk("reset/errs", {30'd0, err_misalign, err_timeout}, 0);
        chk("reset/bus_fields",
            32'(bus_we) | bus_addr | bus_wdata | 32'(bus_wstrb), 0);
        chk("reset/rdata", rdata, 0);
        chk("reset/stall", 32'(stall), 0);
        reset = 1'b0;

        for (int i = 0; i < tbl.size(); i++)
            run_access(tbl[i], $sformatf("vec%0d", i));

        v = '{0, 2, 32'h208, 0, 0, TO, 32'h22222222, 0, 0, 0, 0};
        run_access(v, "late/timeout");
        bus_rvalid = 1'b1;
        bus_rdata = 32'hFFFFFFFF;
        @(negedge clk);
        chk("late/no_done", 32'(rsp_done), 0);
        chk("late/no_valid", 32'(bus_valid), 0);
        @(posedge clk); #1;
        bus_rvalid = 1'b0;
        @(negedge clk);
        chk("late/rdata", rdata, 0);
        @(posedge clk); #1;
        v = '{0, 2, 32'h20C, 0, 0, 1, 32'h0BADF00D,
              0, 0, 0, 32'h0BADF00D};
        run_access(v, "late/next_lw");

        req_valid = 1; req_we = 0; req_funct3 = 3'd2;
        req_addr = 32'h300; bus_ready = 0; bus_rvalid = 0;
        @(posedge clk); #1;
        #1 chk("rst_addr/valid_before", 32'(bus_valid), 1);
        reset = 1'b1;
        #1 chk("rst_addr/valid_drop", 32'(bus_valid), 0);
        chk("rst_addr/rdata_cleared", rdata, 0);
        req_valid = 0;
        @(posedge clk); #1;
        reset = 1'b0;

        req_valid = 1; req_addr = 32'h304; bus_ready = 1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        bus_ready = 0;
        #1 chk("rst_resp/resp_no_valid", 32'(bus_valid), 0);
        chk("rst_resp/stall_held", 32'(stall), 1);
        reset = 1'b1;
        #1 chk("rst_resp/addr_cleared", bus_addr, 0);
        chk("rst_resp/no_done", 32'(rsp_done), 0);
        req_valid = 0;
        @(posedge clk); #1;
        reset = 1'b0;
        v = '{1, 0, 32'h007, 32'h0000005A, 0, 1, 0,
              0, 4'h8, 32'h5A5A5A5A, 0};
        run_access(v, "rst_resp/sb");

        for (int i = 0; i < 60; i++) begin
            v.we = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 3) == 0) begin
                v.f3 = 3'($urandom_range(0, 7));
            end else if (v.we) begin
                v.f3 = 3'($urandom_range(0, 2));
            end else begin
                v.f3 = 3'($urandom_range(0, 4));
                if (v.f3 == 3'd3) v.f3 = 3'd5;
            end
            v.addr = $urandom;
            if ($urandom_range(0, 1) == 1) v.addr[1:0] = 2'b00;
            v.wdata = $urandom;
            v.rword = $urandom;
            v.rd = $urandom_range(0, 3);
            if ($urandom_range(0, 9) == 0) v.rd = 20;
            v.rv = v.rd + $urandom_range(0, 3);
            if ($urandom_range(0, 9) == 0) v.rv = v.rd + TO;
            v = model(v);
            run_access(v, $sformatf("rand%0d", i));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/lsu_bus_bridge.md
Name: lsu_bus_bridge

Overview:
- Load/store unit between the core datapath's data-memory port and a slower handshaked memory bus. Sits directly downstream of the datapath's ALU result / store-data path.
- Converts RV32I byte, half and word accesses into word-aligned bus transactions with byte strobes. Sign- or zero-extends load data.
- Stalls the core until each access completes, faults on misalignment, or times out.

Parameters:
TIMEOUT, 255, max cycles from bus_valid assertion to response before an access is aborted (1..65535)
CNT_W, 16, width of the timeout counter

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
req_valid  in  1  core requests a memory access (load or store) this cycle
req_we  in  1  1 = store, 0 = load
req_funct3  in  3  RV32I funct3 of the load/store
req_addr  in  32  byte address (ALU result)
req_wdata  in  32  store data (rs2)
stall  out  1  hold PC and pipeline registers; combinational
rsp_done  out  1  one-cycle pulse: access finished; core advances at this edge
rdata  out  32  extended load result, valid when rsp_done=1
err_misalign  out  1  valid with rsp_done: misaligned or illegal funct3
err_timeout  out  1  valid with rsp_done: bus did not respond in time
bus_valid  out  1  request valid
bus_ready  in  1  bus accepts request
bus_we  out  1  write request
bus_addr  out  32  word-aligned address {req_addr[31:2],2'b00}
bus_wdata  out  32  lane-replicated write data
bus_wstrb  out  4  byte enables (0000 for reads)
bus_rvalid  in  1  response/ack valid (returned for reads and writes)
bus_rdata  in  32  read word

Behaviour:
- Reset: state IDLE, counter 0. All registered outputs 0: bus_valid, bus_we, bus_addr, bus_wdata, bus_wstrb, rdata, rsp_done, err_*. Reset mid-transaction abandons the access; bus_valid drops asynchronously.
- States: IDLE, ADDR, RESP, DONE.
- stall = req_valid && state != DONE.
- IDLE:
  - If req_valid and the access is legal and aligned: capture addr/strobe/data/we/funct3 into registers, go to ADDR.
  - If req_valid and illegal or misaligned: go to DONE with err_misalign=1 and no bus activity.
- Legality:
  - funct3 3, 6, 7 are illegal.
  - Stores with funct3 4 or 5 are illegal.
  - Word requires addr[1:0]=00. Half requires addr[0]=0.
- ADDR:
  - bus_valid=1 with all bus_* fields held stable until bus_ready. bus_valid never depends on bus_ready.
  - On bus_ready, go to RESP.
  - If bus_ready and bus_rvalid occur in the same cycle, go straight to DONE and capture data.
- RESP: on bus_rvalid, capture data and go to DONE.
- Timeout:
  - The counter runs through ADDR and RESP and clears on entry to ADDR.
  - When it reaches TIMEOUT with no completion: drop bus_valid, go to DONE with err_timeout=1, rdata=0.
  - A late rvalid is ignored.
- DONE:
  - Lasts exactly one cycle: rsp_done=1, stall=0. Always returns to IDLE.
  - req_valid seen in DONE belongs to the retiring instruction and is ignored.
  - The next request is taken the following cycle, so back-to-back accesses cost at least 3 cycles each: IDLE, ADDR, DONE.
- bus_rvalid in IDLE or DONE is ignored.
- Strobes and write data (off = addr[1:0]):
  - SB: wstrb = 0001<<off, wdata = {4{d[7:0]}}.
  - SH: wstrb = 0011<<off, wdata = {2{d[15:0]}}.
  - SW: wstrb = 1111.
  - Reads: wstrb = 0000.
- Load extraction from the captured word, using the captured off:
  - LB / LBU: byte at off, sign- or zero-extended.
  - LH / LHU: half at off[1], sign- or zero-extended.
  - LW: whole word.
- rdata is registered. It holds its value after DONE until the next completed load. Stores and errors update rdata to 0.
- err_* flags are registered, asserted only in the DONE cycle, and mutually exclusive.

Test Plan:
- LW 0x100, bus_ready immediate, rvalid 2 cycles later with 0xDEADBEEF → bus_addr=0x100, wstrb=0000, rsp_done once, rdata=0xDEADBEEF, stall high until DONE.
- LB 0x103 and LBU 0x103, rdata word 0x80112233 → rdata=0xFFFFFF80, then 0x00000080.
- SH 0x0A2, wdata=0x1234ABCD, bus_ready delayed 3 cycles → bus_valid and fields stable for 3 cycles, wstrb=1100, bus_wdata=0xABCDABCD, bus_addr=0x0A0.
- LW 0x101, then SH 0x003, then funct3=3 → each yields rsp_done with err_misalign=1, bus_valid never asserted, stall for one cycle only.
- TIMEOUT=8, bus_ready=1, never rvalid → err_timeout at cycle 8 after bus_valid; a late rvalid is ignored; the next LW completes normally.
- Assert reset in RESP → bus_valid=0 and state IDLE immediately; a fresh SB 0x7 gives wstrb=1000.
